// File: rtl/demux_2to4_l1.sv
// demux_2to4_l1
// Deserialises two independent double-rate lanes into four parallel words.
// Each lane carries a word pair across an even slot and an odd slot of clk_2f.
// The even-slot word is parked in a hold register. On the odd-slot edge the
// pair is presented together. Outputs therefore change only on odd-slot edges
// and hold for two clk_2f cycles, which is one clk_f period.
module demux_2to4_l1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in1,
  input  logic             valid_in1,
  input  logic [WIDTH-1:0] data_in2,
  input  logic             valid_in2,
  output logic [WIDTH-1:0] data_out0,
  output logic [WIDTH-1:0] data_out1,
  output logic [WIDTH-1:0] data_out2,
  output logic [WIDTH-1:0] data_out3,
  output logic             valid_out0,
  output logic             valid_out1,
  output logic             valid_out2,
  output logic             valid_out3,
  output logic             selector
);

  typedef enum logic {
    PHASE_EVEN = 1'b0,
    PHASE_ODD  = 1'b1
  } phase_t;

  phase_t           phase;
  logic [WIDTH-1:0] hold_a_data;
  logic             hold_a_valid;
  logic [WIDTH-1:0] hold_b_data;
  logic             hold_b_valid;

  assign selector = phase;

  // Phase toggle, even-slot capture and odd-slot output update. Invalid slots are zeroed so stale data never leaks out.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      phase        <= PHASE_EVEN;
      hold_a_data  <= '0;
      hold_a_valid <= 1'b0;
      hold_b_data  <= '0;
      hold_b_valid <= 1'b0;
      data_out0    <= '0;
      data_out1    <= '0;
      data_out2    <= '0;
      data_out3    <= '0;
      valid_out0   <= 1'b0;
      valid_out1   <= 1'b0;
      valid_out2   <= 1'b0;
      valid_out3   <= 1'b0;
    end else if (phase == PHASE_EVEN) begin
      hold_a_data  <= valid_in1 ? data_in1 : '0;
      hold_a_valid <= valid_in1;
      hold_b_data  <= valid_in2 ? data_in2 : '0;
      hold_b_valid <= valid_in2;
      phase        <= PHASE_ODD;
    end else begin
      data_out0    <= hold_a_data;
      valid_out0   <= hold_a_valid;
      data_out1    <= valid_in1 ? data_in1 : '0;
      valid_out1   <= valid_in1;
      data_out2    <= hold_b_data;
      valid_out2   <= hold_b_valid;
      data_out3    <= valid_in2 ? data_in2 : '0;
      valid_out3   <= valid_in2;
      phase        <= PHASE_EVEN;
    end
  end

endmodule

// File: tb/tb_demux_2to4_l1.sv
// Testbench for demux_2to4_l1.
// The stimulus side drives one clk_2f edge at a time. After each edge it
// pushes the full expected output state into a queue. The expected state comes
// from a pair-level reference model. A monitor pops one record at every falling
// edge and compares it with the DUT.
module tb_demux_2to4_l1;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic                  sel;
    logic [3:0]            v;
    logic [3:0][WIDTH-1:0] d;
  } exp_t;

  logic             clk_2f = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] data_in1, data_in2;
  logic             valid_in1, valid_in2;
  logic [WIDTH-1:0] data_out0, data_out1, data_out2, data_out3;
  logic             valid_out0, valid_out1, valid_out2, valid_out3;
  logic             selector;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   stim_done   = 1'b0;

  // reference model state: edges since reset, parked even-slot words, last presented pair set
  int               m_edges = 0;
  logic [WIDTH-1:0] m_even_word[2];
  logic             m_even_ok[2];
  exp_t             m_out = '0;

  demux_2to4_l1 #(.WIDTH(WIDTH)) dut (
    .clk_2f     (clk_2f),
    .reset      (reset),
    .data_in1   (data_in1),
    .valid_in1  (valid_in1),
    .data_in2   (data_in2),
    .valid_in2  (valid_in2),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .data_out2  (data_out2),
    .data_out3  (data_out3),
    .valid_out0 (valid_out0),
    .valid_out1 (valid_out1),
    .valid_out2 (valid_out2),
    .valid_out3 (valid_out3),
    .selector   (selector)
  );

  always #5 clk_2f = ~clk_2f;

  // Drive one edge's inputs, let the edge happen, then record what the outputs must look like.
  task automatic applyStimulus(input logic rst, input logic [WIDTH-1:0] da, input logic va,
                               input logic [WIDTH-1:0] db, input logic vb);
    reset     = rst;
    data_in1  = da;
    valid_in1 = va;
    data_in2  = db;
    valid_in2 = vb;
    @(posedge clk_2f);
    if (rst) begin
      m_edges        = 0;
      m_even_word[0] = '0; m_even_word[1] = '0;
      m_even_ok[0]   = 1'b0; m_even_ok[1] = 1'b0;
      m_out          = '0;
    end else begin
      if (m_edges % 2 == 0) begin
        m_even_word[0] = da; m_even_ok[0] = va;
        m_even_word[1] = db; m_even_ok[1] = vb;
      end else begin
        m_out.d[0] = m_even_ok[0] ? m_even_word[0] : '0;
        m_out.v[0] = m_even_ok[0];
        m_out.d[1] = va ? da : '0;
        m_out.v[1] = va;
        m_out.d[2] = m_even_ok[1] ? m_even_word[1] : '0;
        m_out.v[2] = m_even_ok[1];
        m_out.d[3] = vb ? db : '0;
        m_out.v[3] = vb;
      end
      m_edges++;
    end
    m_out.sel = (m_edges % 2 == 1);
    exp_q.push_back(m_out);
    #1;
  endtask

  // Compare one expected record against the live DUT outputs.
  task automatic checkOutput(input exp_t e);
    logic [3:0][WIDTH-1:0] ad;
    logic [3:0]            av;
    bit                    bad;
    ad  = {data_out3, data_out2, data_out1, data_out0};
    av  = {valid_out3, valid_out2, valid_out1, valid_out0};
    bad = 1'b0;
    vectors++;
    if (selector !== e.sel) begin
      $display("[TB] FAIL selector @%0t: got %b want %b", $time, selector, e.sel);
      bad = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      if (ad[i] !== e.d[i] || av[i] !== e.v[i]) begin
        $display("[TB] FAIL out%0d @%0t: got data=%h valid=%b want data=%h valid=%b",
                 i, $time, ad[i], av[i], e.d[i], e.v[i]);
        bad = 1'b1;
      end
    end
    if (bad) miscompares++;
  endtask

  // Monitor: one record per edge, checked half a cycle after that edge.
  initial begin
    forever begin
      @(negedge clk_2f);
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  // Stimulus: directed pair scenarios followed by a randomized stream with sporadic resets.
  initial begin
    reset = 1'b1; data_in1 = '0; data_in2 = '0; valid_in1 = 1'b0; valid_in2 = 1'b0;
    #2;
    applyStimulus(1'b1, 8'h3C, 1'b1, 8'h5A, 1'b1);
    applyStimulus(1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // basic pair on both lanes, then idle pair to observe the two-cycle hold
    applyStimulus(1'b0, 8'hA1, 1'b1, 8'hC3, 1'b1);
    applyStimulus(1'b0, 8'hB2, 1'b1, 8'hD4, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // invalid even slot on lane A, lane B carries a full pair
    applyStimulus(1'b0, 8'hFF, 1'b0, 8'h12, 1'b1);
    applyStimulus(1'b0, 8'h55, 1'b1, 8'h34, 1'b1);

    // streaming incrementing pairs on lane A
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b0, WIDTH'(i), 1'b1, WIDTH'($urandom), 1'($urandom));

    // reset right after the even-slot capture of 77
    applyStimulus(1'b0, 8'h77, 1'b1, 8'h77, 1'b1);
    applyStimulus(1'b1, 8'h88, 1'b1, 8'h88, 1'b1);
    applyStimulus(1'b0, 8'h91, 1'b1, 8'h93, 1'b1);
    applyStimulus(1'b0, 8'h92, 1'b1, 8'h94, 1'b1);

    // fully idle inputs, selector keeps toggling
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, WIDTH'($urandom), 1'b0, WIDTH'($urandom), 1'b0);

    // lane B only
    applyStimulus(1'b0, 8'hEE, 1'b0, 8'h11, 1'b1);
    applyStimulus(1'b0, 8'hDD, 1'b0, 8'h22, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // randomized traffic
    for (int i = 0; i < 300; i++)
      applyStimulus(($urandom_range(0, 24) == 0), WIDTH'($urandom), 1'($urandom),
                    WIDTH'($urandom), 1'($urandom));

    stim_done = 1'b1;
  end

  // Wait for the stimulus and the scoreboard to drain, with a bounded timeout.
  initial begin
    wait (stim_done);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk_2f);
    #1;
    if (exp_q.size() > 0) begin
      $display("[TB] FAIL drain: got %0d records pending want 0", exp_q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/demux_2to4_l1.md
DEMUX_2TO4_L1 -- requirements
Module: demux_2to4_l1

Interface
REQ-001 Parameter: WIDTH, 8, data lane width in bits.
REQ-002 Port: clk_2f  input  1  double-rate clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk_2f.
REQ-004 Port: data_in1  input  WIDTH  serialized lane A, carrying the word pair for out0/out1.
REQ-005 Port: valid_in1  input  1  qualifier for data_in1.
REQ-006 Port: data_in2  input  WIDTH  serialized lane B, carrying the word pair for out2/out3.
REQ-007 Port: valid_in2  input  1  qualifier for data_in2.
REQ-008 Port: data_out0..data_out3  output  WIDTH each  de-serialized parallel words.
REQ-009 Port: valid_out0..valid_out3  output  1 each  qualifier per output word.
REQ-010 Port: selector  output  1  current phase bit (0 = even slot, 1 = odd slot).

Function
REQ-011 The block SHALL hold a phase flop (selector) that is 0 on the first cycle after reset and toggles on every clk_2f edge thereafter, independent of valid inputs.
REQ-012 In phase 0 the block SHALL capture data_in1/valid_in1 into hold register A and data_in2/valid_in2 into hold register B; outputs SHALL NOT change on this edge.
REQ-013 On the phase-1 edge the block SHALL register the following simultaneously: data_out0/valid_out0 from hold A, data_out1/valid_out1 from the live lane-A inputs, data_out2/valid_out2 from hold B, and data_out3/valid_out3 from the live lane-B inputs.
REQ-014 Outputs SHALL update only on phase-1 edges and stay stable for exactly 2 clk_2f cycles (effective rate clk_f).
REQ-015 Latency: an even-slot word SHALL appear 2 edges after capture; an odd-slot word SHALL appear 1 edge after its own edge.
REQ-016 Any output whose slot valid was 0 SHALL present data 0 with valid 0; data on invalid slots is discarded, not held.
REQ-017 Lanes A and B SHALL be fully independent: a valid on one lane SHALL not affect the other lane's outputs.
REQ-018 Each slot's valid SHALL be carried independently: a pair with only one valid slot yields exactly one asserted valid_out for that lane.
REQ-019 The block SHALL contain no back-pressure; a word presented in a slot is consumed unconditionally.
REQ-020 Phase has no wrap condition other than the 0->1->0 toggle; no counters wider than 1 bit are required beyond WIDTH-wide hold registers.

Reset
REQ-021 While reset=1 at an edge: selector, both hold registers (data and valid), all data_outN and all valid_outN SHALL be 0 after that edge.
REQ-022 Reset asserted mid-pair (after a phase-0 capture, before the phase-1 edge) SHALL discard the captured half-pair; no output SHALL reflect it.
REQ-023 On the first edge with reset=0, the block SHALL treat the inputs as phase 0 (even slot).
REQ-024 Outputs SHALL remain 0 until the first phase-1 edge after reset release.

Verification
REQ-025 Reset release, then lane A phase0=8'hA1 v=1, phase1=8'hB2 v=1; lane B 8'hC3/8'hD4 v=1 -> after phase-1 edge: out0=A1, out1=B2, out2=C3, out3=D4, all valids 1, held 2 cycles.
REQ-026 Lane A phase0 v=0 with data 8'hFF, phase1=8'h55 v=1 -> out0=00/valid_out0=0, out1=55/valid_out1=1; lane B unaffected.
REQ-027 Streaming 8 consecutive pairs with incrementing data 8'h00..8'h0F on lane A -> out0/out1 = (00,01),(02,03)...(0E,0F), each stable 2 cycles, no gaps.
REQ-028 Reset pulsed for 1 cycle right after phase-0 capture of 8'h77 -> all outputs 0; 8'h77 never appears; next pair maps normally starting from phase 0.
REQ-029 All inputs valid=0 continuously -> all valid_outN=0 and data_outN=0; selector keeps toggling 0,1,0,1.
REQ-030 Lane B only valid (8'h11, 8'h22) while lane A idle -> out2=11, out3=22 with valids 1; out0/out1 = 0 with valids 0.
